// File: rtl/decoder_pkg.sv
// Shared constants and types for the 3-to-8 decoder slice.
package decoder_pkg;

    localparam int unsigned SEL_W = 3;
    localparam int unsigned OUT_W = 1 << SEL_W;

    typedef logic [OUT_W-1:0] dec_vec_t;

    // Apply the output polarity: active-low outputs are the bitwise inverse.
    function automatic dec_vec_t apply_polarity(input dec_vec_t v, input bit active_low);
        return active_low ? ~v : v;
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational one-hot decoder: sets bit d_i when enabled, all-zero otherwise.
module onehot_dec
    import decoder_pkg::*;
(
    input  logic [SEL_W-1:0] d_i,
    input  logic             en_i,
    output dec_vec_t         vec_o
);

    // Every code 0..OUT_W-1 maps to exactly one bit; disabled yields no bit.
    always_comb begin
        vec_o = '0;
        if (en_i) begin
            vec_o[d_i] = 1'b1;
        end
    end

endmodule

// File: rtl/decoder_3_to_8.sv
// 3-to-8 decoder with optional output register and selectable output polarity.
module decoder_3_to_8
    import decoder_pkg::*;
#(
    parameter bit OUT_REG    = 1'b1,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [SEL_W-1:0] d_i,
    output logic [OUT_W-1:0] y_o,
    output logic             valid_o
);

    dec_vec_t dec_vec;
    dec_vec_t dec_out;
    logic     valid_out;

    onehot_dec u_onehot_dec (
        .d_i   (d_i),
        .en_i  (en_i),
        .vec_o (dec_vec)
    );

    generate
        if (OUT_REG) begin : g_reg
            dec_vec_t dec_d;
            dec_vec_t dec_q;
            logic     valid_d;
            logic     valid_q;

            // Next-state: capture the current decode and its enable.
            always_comb begin
                dec_d   = dec_vec;
                valid_d = en_i;
            end

            // Output register; reset clears it asynchronously.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    dec_q   <= '0;
                    valid_q <= 1'b0;
                end else begin
                    dec_q   <= dec_d;
                    valid_q <= valid_d;
                end
            end

            // Registered stage drives the polarity logic.
            always_comb begin
                dec_out   = dec_q;
                valid_out = valid_q;
            end
        end else begin : g_comb
            // Pass-through path; reset gates outputs inactive without a clock.
            always_comb begin
                dec_out   = '0;
                valid_out = 1'b0;
                if (rst_ni) begin
                    dec_out   = dec_vec;
                    valid_out = en_i;
                end
            end
        end
    endgenerate

    // Polarity applies to y_o only; valid_o is always active-high.
    always_comb begin
        y_o     = apply_polarity(dec_out, ACTIVE_LOW);
        valid_o = valid_out;
    end

endmodule

// File: tb/tb_decoder_3_to_8.sv
// Self-checking bench for decoder_3_to_8: registered, active-low and combinational variants.
module tb_decoder_3_to_8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [2:0] d;

    logic [7:0] y_r, y_a, y_c;
    logic       v_r, v_a, v_c;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected state of the registered outputs (positive polarity).
    logic [7:0] prev_y;
    logic       prev_v;

    always #5 clk = ~clk;

    decoder_3_to_8 #(.OUT_REG(1'b1), .ACTIVE_LOW(1'b0)) dut_reg (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .d_i(d), .y_o(y_r), .valid_o(v_r)
    );

    decoder_3_to_8 #(.OUT_REG(1'b1), .ACTIVE_LOW(1'b1)) dut_al (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .d_i(d), .y_o(y_a), .valid_o(v_a)
    );

    decoder_3_to_8 #(.OUT_REG(1'b0), .ACTIVE_LOW(1'b0)) dut_comb (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .d_i(d), .y_o(y_c), .valid_o(v_c)
    );

    typedef struct {
        logic       en;
        logic [2:0] d;
        logic [7:0] y;
        logic       v;
    } vec_t;

    // Reference: enabled code n selects the bit of weight 2**n.
    function automatic logic [7:0] model_y(input logic e, input logic [2:0] sel);
        int unsigned w;
        w = 1;
        for (int unsigned i = 0; i < 32'(sel); i++) w = w * 2;
        return e ? 8'(w) : 8'h00;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1; drives inputs, checks the combinational and
    // pre-edge registered values, then the registered values after the edge.
    task automatic apply(input logic e, input logic [2:0] sel, input logic [7:0] ey, input logic ev);
        en = e;
        d  = sel;
        #1;
        check("comb_y", y_c, ey);
        check("comb_v", {7'b0, v_c}, {7'b0, ev});
        check("reg_hold_y", y_r, prev_y);
        check("reg_hold_v", {7'b0, v_r}, {7'b0, prev_v});
        @(posedge clk);
        #1;
        check("reg_y", y_r, ey);
        check("reg_v", {7'b0, v_r}, {7'b0, ev});
        check("al_y", y_a, ~ey);
        check("al_v", {7'b0, v_a}, {7'b0, ev});
        prev_y = ey;
        prev_v = ev;
    endtask

    task automatic check_inactive(input string name);
        check({name, "_reg_y"}, y_r, 8'h00);
        check({name, "_reg_v"}, {7'b0, v_r}, 8'h00);
        check({name, "_al_y"}, y_a, 8'hFF);
        check({name, "_al_v"}, {7'b0, v_a}, 8'h00);
        check({name, "_comb_y"}, y_c, 8'h00);
        check({name, "_comb_v"}, {7'b0, v_c}, 8'h00);
    endtask

    // One-hot/one-cold property sampled on every falling edge out of reset.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("onehot_reg", {7'b0, v_r ? $onehot(y_r) : (y_r == 8'h00)}, 8'h01);
            check("onecold_al", {7'b0, v_a ? $onehot(~y_a) : (y_a == 8'hFF)}, 8'h01);
            check("onehot_comb", {7'b0, v_c ? $onehot(y_c) : (y_c == 8'h00)}, 8'h01);
        end
    end

    initial begin
        vec_t tbl[10];
        logic       re;
        logic [2:0] rd;

        tbl[0] = '{1'b1, 3'd0, 8'h01, 1'b1};
        tbl[1] = '{1'b1, 3'd1, 8'h02, 1'b1};
        tbl[2] = '{1'b1, 3'd2, 8'h04, 1'b1};
        tbl[3] = '{1'b1, 3'd3, 8'h08, 1'b1};
        tbl[4] = '{1'b1, 3'd4, 8'h10, 1'b1};
        tbl[5] = '{1'b1, 3'd5, 8'h20, 1'b1};
        tbl[6] = '{1'b1, 3'd6, 8'h40, 1'b1};
        tbl[7] = '{1'b1, 3'd7, 8'h80, 1'b1};
        tbl[8] = '{1'b0, 3'd6, 8'h00, 1'b0};
        tbl[9] = '{1'b1, 3'd7, 8'h80, 1'b1};

        // Reset held with an enabled code present.
        rst_n = 1'b0;
        en    = 1'b1;
        d     = 3'd5;
        #3;
        check_inactive("rst_pre_edge");
        repeat (2) @(posedge clk);
        #1;
        check_inactive("rst_after_edges");

        // Release away from an edge; first decode lands on the next edge.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_hold_y", y_r, 8'h00);
        check("release_comb_y", y_c, 8'h20);
        @(posedge clk);
        #1;
        check("first_decode_y", y_r, 8'h20);
        check("first_decode_v", {7'b0, v_r}, 8'h01);
        check("first_decode_al", y_a, 8'hDF);
        prev_y = 8'h20;
        prev_v = 1'b1;

        // Sweep, disable, then back to code 7 on consecutive cycles.
        for (int i = 0; i < 10; i++) begin
            apply(tbl[i].en, tbl[i].d, tbl[i].y, tbl[i].v);
        end

        // Mid-cycle asynchronous reset while y_o is 8'h80.
        check("pre_async_y", y_r, 8'h80);
        #2;
        rst_n = 1'b0;
        #1;
        check_inactive("async_rst");
        @(posedge clk);
        #1;
        check_inactive("async_rst_edge");
        rst_n  = 1'b1;
        prev_y = 8'h00;
        prev_v = 1'b0;

        // Spot cases: active-low code 2 and combinational code 4.
        apply(1'b1, 3'd2, 8'h04, 1'b1);
        check("al_code2", y_a, 8'hFB);
        apply(1'b1, 3'd4, 8'h10, 1'b1);

        // Randomized stimulus against the reference model.
        for (int i = 0; i < 200; i++) begin
            re = ($urandom_range(0, 3) != 0);
            rd = 3'($urandom_range(0, 7));
            apply(re, rd, model_y(re, rd), re);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
